// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-read-port integer register file with a
// pending-write scoreboard for the KLP32 decode/writeback path.
//   - Decode reads operands through NRD independent read ports and marks
//     destinations busy at issue.
//   - Writeback writes results and clears busy bits.
//   - Register 0 is hardwired to zero and is never busy.
// Optional feature macro: REGFILE_BYPASS_EN
//   Defined   -> same-cycle write-through from the writeback port to any read
//                port that names the register being written.
//   Undefined -> reads return stored state only; new data is visible next cycle.

// ---------------------------------------------------------------------------
// One read port: selects data and busy for its address from the array, with
// an optional write-through override from the writeback port.
// ---------------------------------------------------------------------------
module regfile_mp_rdport #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic [AW-1:0]               rd_addr,
  input  logic [NREGS-1:0][XLEN-1:0]  regs,
  input  logic [NREGS-1:0]            busy,
`ifdef REGFILE_BYPASS_EN
  input  logic                        byp_vld,
  input  logic [AW-1:0]               byp_addr,
  input  logic [XLEN-1:0]             byp_data,
  input  logic                        byp_busy,
`endif
  output logic [XLEN-1:0]             rd_data,
  output logic                        rd_busy
);

  // Stored value, replaced by the in-flight writeback when addresses match.
  always_comb begin
    rd_data = regs[rd_addr];
    rd_busy = busy[rd_addr];
`ifdef REGFILE_BYPASS_EN
    if (byp_vld && (byp_addr == rd_addr)) begin
      rd_data = byp_data;
      // A same-cycle issue to this register means a newer producer exists.
      rd_busy = byp_busy;
    end
`endif
  end

endmodule

// ---------------------------------------------------------------------------
// Top: storage, scoreboard and an array of read ports.
// ---------------------------------------------------------------------------
module regfile_mp #(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  parameter  int NRD   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NRD*AW-1:0]     rd_addr,
  output logic [NRD*XLEN-1:0]   rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [XLEN-1:0]       wr_data,
  input  logic                  iss_en,
  input  logic [AW-1:0]         iss_addr,
  output logic [NREGS-1:0]      busy_vec
);

  logic [NREGS-1:0][XLEN-1:0] regs_q, regs_d;
  logic [NREGS-1:0]           busy_q, busy_d;

  // Writes to register 0 are dropped; issue to register 0 is ignored.
  logic wr_ok, iss_ok;
  assign wr_ok  = wr_en  && (wr_addr  != '0);
  assign iss_ok = iss_en && (iss_addr != '0);

  // Next state: writeback updates data and clears busy; a same-cycle issue
  // to the same register is applied last so it wins the busy bit.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_ok) begin
      regs_d[wr_addr] = wr_data;
      busy_d[wr_addr] = 1'b0;
    end
    if (iss_ok) begin
      busy_d[iss_addr] = 1'b1;
    end
    // Keep register 0 structurally zero and never busy.
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
  end

  // State registers; reset discards all data and pending writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

`ifdef REGFILE_BYPASS_EN
  logic byp_busy;
  assign byp_busy = iss_en && (iss_addr == wr_addr);
`endif

  // Independent read ports; all of them may name the same register.
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    regfile_mp_rdport #(
      .XLEN  (XLEN),
      .NREGS (NREGS),
      .AW    (AW)
    ) u_rd (
      .rd_addr  (rd_addr[i*AW +: AW]),
      .regs     (regs_q),
      .busy     (busy_q),
`ifdef REGFILE_BYPASS_EN
      .byp_vld  (wr_ok),
      .byp_addr (wr_addr),
      .byp_data (wr_data),
      .byp_busy (byp_busy),
`endif
      .rd_data  (rd_data[i*XLEN +: XLEN]),
      .rd_busy  (rd_busy[i])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: table of directed vectors with
// hand-computed expectations, plus hand-written bypass and reset sequences.
// Outputs are sampled 2 ns after the falling edge, well away from posedge.
module tb_regfile_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 3;
  localparam int AW    = 5;

  logic                 clk;
  logic                 rst_n;
  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*XLEN-1:0]  rd_data;
  logic [NRD-1:0]       rd_busy;
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic [XLEN-1:0]      wr_data;
  logic                 iss_en;
  logic [AW-1:0]        iss_addr;
  logic [NREGS-1:0]     busy_vec;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .busy_vec (busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic                          ie;
    logic [AW-1:0]                 ia;
    logic                          we;
    logic [AW-1:0]                 wa;
    logic [XLEN-1:0]               wd;
    logic [NRD-1:0][AW-1:0]        ra;
    logic [NRD-1:0][XLEN-1:0]      ed;
    logic [NRD-1:0]                eb;
    logic [NREGS-1:0]              ebv;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic vec_t mk(logic ie, logic [4:0] ia, logic we, logic [4:0] wa,
                              logic [31:0] wd, logic [4:0] a0, logic [4:0] a1,
                              logic [4:0] a2, logic [31:0] d0, logic [31:0] d1,
                              logic [31:0] d2, logic [2:0] b, logic [31:0] bv);
    vec_t v;
    v.ie = ie; v.ia = ia; v.we = we; v.wa = wa; v.wd = wd;
    v.ra[0] = a0; v.ra[1] = a1; v.ra[2] = a2;
    v.ed[0] = d0; v.ed[1] = d1; v.ed[2] = d2;
    v.eb = b; v.ebv = bv;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic ie, input logic [4:0] ia, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
    iss_en = ie; iss_addr = ia; wr_en = we; wr_addr = wa; wr_data = wd;
    rd_addr = {a2, a1, a0};
  endtask

  task automatic chk_out(input string nm, input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [2:0] b, input logic [31:0] bv);
    chk({nm, ".data"}, 128'(rd_data), 128'({d2, d1, d0}));
    chk({nm, ".busy"}, 128'(rd_busy), 128'(b));
    chk({nm, ".bvec"}, 128'(busy_vec), 128'(bv));
  endtask

  localparam logic [31:0] D  = 32'hDEADBEEF;
  localparam logic [31:0] K  = 32'h12345678;
  localparam logic [31:0] CF = 32'h0000CAFE;

  vec_t vt[17];

  initial begin
    // Each vector: inputs for one cycle, outputs expected before that edge.
    // No vector reads the register being written in the same cycle, so the
    // table holds with or without write-through.
    vt[0]  = mk(0, 0, 0, 0, 0,             0, 1, 2,   0, 0, 0,       3'b000, 0);
    vt[1]  = mk(0, 0, 1, 1, D,             2, 3, 0,   0, 0, 0,       3'b000, 0);
    vt[2]  = mk(0, 0, 0, 0, 0,             1, 1, 1,   D, D, D,       3'b000, 0);
    vt[3]  = mk(0, 0, 0, 0, 0,             2, 0, 1,   0, 0, D,       3'b000, 0);
    vt[4]  = mk(1, 0, 1, 0, 32'hFFFFFFFF,  1, 2, 3,   D, 0, 0,       3'b000, 0);
    vt[5]  = mk(0, 0, 0, 0, 0,             0, 0, 0,   0, 0, 0,       3'b000, 0);
    vt[6]  = mk(1, 5, 0, 0, 0,             5, 0, 1,   0, 0, D,       3'b000, 0);
    vt[7]  = mk(1, 5, 1, 5, 32'h99,        0, 1, 2,   0, D, 0,       3'b000, 32'h20);
    vt[8]  = mk(0, 0, 0, 0, 0,             5, 5, 0,   32'h99, 32'h99, 0, 3'b011, 32'h20);
    vt[9]  = mk(0, 0, 1, 5, 32'h11,        1, 0, 2,   D, 0, 0,       3'b000, 32'h20);
    vt[10] = mk(0, 0, 0, 0, 0,             5, 5, 5,   32'h11, 32'h11, 32'h11, 3'b000, 0);
    vt[11] = mk(1, 6, 1, 3, K,             1, 2, 0,   D, 0, 0,       3'b000, 0);
    vt[12] = mk(1, 6, 0, 0, 0,             3, 6, 0,   K, 0, 0,       3'b010, 32'h40);
    vt[13] = mk(1, 31, 1, 6, CF,           3, 31, 0,  K, 0, 0,       3'b000, 32'h40);
    vt[14] = mk(0, 0, 0, 0, 0,             6, 31, 3,  CF, 0, K,      3'b010, 32'h80000000);
    vt[15] = mk(0, 0, 1, 31, 32'h1,        30, 6, 0,  0, CF, 0,      3'b000, 32'h80000000);
    vt[16] = mk(0, 0, 0, 0, 0,             31, 0, 6,  32'h1, 0, CF,  3'b000, 0);

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk_out("reset", 0, 0, 0, 3'b000, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Every register reads zero and idle after reset.
    for (int a = 0; a < NREGS; a++) begin
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 5'(a), 5'(a), 5'(a));
      #2;
      chk($sformatf("rst_r%0d.data", a), 128'(rd_data), 128'(0));
      chk($sformatf("rst_r%0d.bvec", a), 128'(busy_vec), 128'(0));
    end

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      drive(vt[i].ie, vt[i].ia, vt[i].we, vt[i].wa, vt[i].wd,
            vt[i].ra[0], vt[i].ra[1], vt[i].ra[2]);
      #2;
      chk($sformatf("vec%0d.data", i), 128'(rd_data), 128'(vt[i].ed));
      chk($sformatf("vec%0d.busy", i), 128'(rd_busy), 128'(vt[i].eb));
      chk($sformatf("vec%0d.bvec", i), 128'(busy_vec), 128'(vt[i].ebv));
    end

    // Same-cycle write and read of r4.
    @(negedge clk);
    drive(0, 0, 1, 4, 32'h76767676, 4, 4, 4);
    #2;
`ifdef REGFILE_BYPASS_EN
    chk_out("byp_r4", 32'h76767676, 32'h76767676, 32'h76767676, 3'b000, 0);
`else
    chk_out("byp_r4", 0, 0, 0, 3'b000, 0);
`endif
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 4, 4, 4);
    #2;
    chk_out("r4_next", 32'h76767676, 32'h76767676, 32'h76767676, 3'b000, 0);

    // Same-cycle write, issue and read of r8: issue keeps it busy.
    @(negedge clk);
    drive(1, 8, 1, 8, 32'h55, 8, 8, 8);
    #2;
`ifdef REGFILE_BYPASS_EN
    chk_out("byp_r8_iss", 32'h55, 32'h55, 32'h55, 3'b111, 0);
`else
    chk_out("byp_r8_iss", 0, 0, 0, 3'b000, 0);
`endif
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 8, 8, 8);
    #2;
    chk_out("r8_next", 32'h55, 32'h55, 32'h55, 3'b111, 32'h100);
    @(negedge clk);
    drive(0, 0, 1, 8, 32'h66, 8, 0, 1);
    #2;
`ifdef REGFILE_BYPASS_EN
    chk_out("byp_r8_wb", 32'h66, 0, D, 3'b000, 32'h100);
`else
    chk_out("byp_r8_wb", 32'h55, 0, D, 3'b001, 32'h100);
`endif
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 8, 8, 8);
    #2;
    chk_out("r8_clear", 32'h66, 32'h66, 32'h66, 3'b000, 0);

    // Asynchronous reset between edges clears data and scoreboard at once.
    @(negedge clk);
    drive(1, 9, 1, 7, 32'hA5A5A5A5, 7, 9, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 7, 9, 1);
    #1;
    chk_out("pre_rst", 32'hA5A5A5A5, 0, D, 3'b010, 32'h200);
    rst_n = 1'b0;
    #1;
    chk_out("mid_rst", 0, 0, 0, 3'b000, 0);
    #2;
    rst_n = 1'b1;
    #0.5;
    chk_out("post_rst", 0, 0, 0, 3'b000, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 6, 31, 5);
    #2;
    chk_out("after_rst", 0, 0, 0, 3'b000, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
